// File: rtl/ws281x_pkg.sv
`default_nettype none
// ============================================================================
// ws281x_pkg : FSM encoding and default WS281x timing (50 MHz clock) shared
//              by the serializer and its per-lane shifters.  Rev 1.0
// ============================================================================
package ws281x_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned T0H  = 18;
    localparam int unsigned T1H  = 35;
    localparam int unsigned TSUM = 63;
    localparam int unsigned TRST = 15000;

endpackage

`default_nettype wire

// File: rtl/ws281x_lane_shift.sv
`default_nettype none
// ============================================================================
// ws281x_lane_shift : one lane's pixel shift register and registered NRZ
//                     pulse comparator, driven by the shared timing engine.
// Rev 1.0
// ============================================================================
module ws281x_lane_shift
    import ws281x_pkg::*;
#(
    parameter int WORD_W = 24,
    parameter int TIM_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              send_i,
    input  logic [TIM_W-1:0]  cyc_i,
    input  logic [TIM_W-1:0]  t0h_i,
    input  logic [TIM_W-1:0]  t1h_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              code_o
);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;
    logic              code_q;
    logic              code_d;
    logic [TIM_W-1:0]  thr;

    // The comparator looks at next-cycle values so the line is registered
    // yet already valid in the first cycle after a load or shift.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[WORD_W-2:0], 1'b0};
        end
        thr    = sr_d[WORD_W-1] ? t1h_i : t0h_i;
        code_d = send_i && (cyc_i < thr);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sr_q   <= '0;
            code_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            code_q <= code_d;
        end
    end

    assign code_o = code_q;

endmodule

`default_nettype wire

// File: rtl/ws281x_serializer.sv
`default_nettype none
// ============================================================================
// ws281x_serializer : multi-lane WS281x NRZ line encoder with a shared bit
//                     timing engine and a programmable frame latch gap.
// Rev 1.0
// ============================================================================
module ws281x_serializer
    import ws281x_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int WORD_W = 24,
    parameter int TIM_W  = 8,
    parameter int RST_W  = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [TIM_W-1:0]         t0h_cnt_in,
    input  logic [TIM_W-1:0]         t1h_cnt_in,
    input  logic [TIM_W-1:0]         tim_sum_in,
    input  logic [RST_W-1:0]         rst_cnt_in,
    input  logic                     word_vld_in,
    input  logic                     word_last_in,
    input  logic [CH_NUM*WORD_W-1:0] word_data_in,
    output logic                     word_rdy_out,
    output logic [CH_NUM-1:0]        bit_code_out,
    output logic                     word_done_out,
    output logic                     frame_done_out,
    output logic                     underrun_out
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t             state_q,  state_d;
    logic [TIM_W-1:0]   cyc_q,    cyc_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [RST_W-1:0]   gap_q,    gap_d;
    logic               last_q,   last_d;
    logic [TIM_W-1:0]   t0h_q,    t0h_d;
    logic [TIM_W-1:0]   t1h_q,    t1h_d;
    logic [TIM_W-1:0]   period_q, period_d;
    logic [RST_W-1:0]   rstc_q,   rstc_d;
    logic               word_done_q, word_done_d;
    logic               frame_done_q, frame_done_d;
    logic               underrun_q, underrun_d;

    logic               lane_load;
    logic               lane_shift;
    logic               accept;
    logic               bit_end;
    logic               word_end;
    logic [TIM_W-1:0]   period_in;

    assign period_in = (tim_sum_in < TIM_W'(2)) ? TIM_W'(2) : tim_sum_in;
    assign bit_end   = (state_q == SEND) && (cyc_q == period_q - TIM_W'(1));
    assign word_end  = bit_end && (idx_q == IDX_W'(WORD_W - 1));

    // Reset gates ready so nothing upstream sees a handshake while held.
    assign word_rdy_out = rst_n_in && ((state_q == IDLE) || (word_end && !last_q));
    assign accept       = word_vld_in && word_rdy_out;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        idx_d        = idx_q;
        gap_d        = gap_q;
        last_d       = last_q;
        t0h_d        = t0h_q;
        t1h_d        = t1h_q;
        period_d     = period_q;
        rstc_d       = rstc_q;
        word_done_d  = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        lane_load    = 1'b0;
        lane_shift   = 1'b0;

        if (accept) begin
            t0h_d    = t0h_cnt_in;
            t1h_d    = t1h_cnt_in;
            period_d = period_in;
            rstc_d   = rst_cnt_in;
            last_d   = word_last_in;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND;
                    lane_load = 1'b1;
                    cyc_d     = '0;
                    idx_d     = '0;
                end
            end
            SEND: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (word_end) begin
                        word_done_d = 1'b1;
                        idx_d       = '0;
                        if (last_q) begin
                            if (rstc_q != '0) begin
                                state_d = GAP;
                                gap_d   = '0;
                            end else begin
                                state_d      = IDLE;
                                frame_done_d = 1'b1;
                            end
                        end else if (accept) begin
                            lane_load = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        lane_shift = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + TIM_W'(1);
                end
            end
            GAP: begin
                if (gap_q == rstc_q - RST_W'(1)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    gap_d = gap_q + RST_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            idx_q        <= '0;
            gap_q        <= '0;
            last_q       <= 1'b0;
            t0h_q        <= '0;
            t1h_q        <= '0;
            period_q     <= '0;
            rstc_q       <= '0;
            word_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            last_q       <= last_d;
            t0h_q        <= t0h_d;
            t1h_q        <= t1h_d;
            period_q     <= period_d;
            rstc_q       <= rstc_d;
            word_done_q  <= word_done_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
        ws281x_lane_shift #(
            .WORD_W (WORD_W),
            .TIM_W  (TIM_W)
        ) u_lane (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .load_i   (lane_load),
            .shift_i  (lane_shift),
            .send_i   (state_d == SEND),
            .cyc_i    (cyc_d),
            .t0h_i    (t0h_d),
            .t1h_i    (t1h_d),
            .data_i   (word_data_in[k*WORD_W +: WORD_W]),
            .code_o   (bit_code_out[k])
        );
    end

    assign word_done_out  = word_done_q;
    assign frame_done_out = frame_done_q;
    assign underrun_out   = underrun_q;

endmodule

`default_nettype wire
